// File: rtl/gate3_pkg.sv
// Shared state encoding, widths and reference truth tables for the 3-input gate exerciser.
package gate3_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int VEC_W    = 3;
  localparam int LOOP_W   = 4;
  localparam int SETTLE_W = 4;

  localparam logic [7:0] TT_NAND3 = 8'h7F;
  localparam logic [7:0] TT_AND3  = 8'h80;
  localparam logic [7:0] TT_NOR3  = 8'h01;

  // Expected gate output for input vector {a,b,c}
  function automatic logic tt_bit(input logic [7:0] tt, input logic [VEC_W-1:0] vec);
    return tt[vec];
  endfunction

endpackage

// File: rtl/gate3_vec_gen.sv
// Input-vector and sweep counter for the gate exerciser; flags the final vector of the final sweep.
module gate3_vec_gen
  import gate3_pkg::*;
#(
  parameter int LOOPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  output logic [VEC_W-1:0] vec,
  output logic             last_vec
);

  localparam logic [LOOP_W-1:0] LAST_LOOP = LOOP_W'(LOOPS - 1);

  logic [VEC_W-1:0]  vec_r;
  logic [LOOP_W-1:0] loop_r;

  // Vector counter; the sweep counter steps on every 7->0 wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_r  <= 3'd0;
      loop_r <= 4'd0;
    end else if (clear) begin
      vec_r  <= 3'd0;
      loop_r <= 4'd0;
    end else if (advance) begin
      vec_r <= vec_r + 3'd1;
      if (vec_r == 3'd7) begin
        loop_r <= loop_r + 4'd1;
      end
    end
  end

  assign vec      = vec_r;
  assign last_vec = (vec_r == 3'd7) && (loop_r == LAST_LOOP);

endmodule

// File: rtl/gate3_exerciser.sv
// Self-test engine: sweeps all {a,b,c} vectors into a 3-input gate and scores its output
// against an expected truth table, reporting pass, mismatch count and first failing vector.
module gate3_exerciser
  import gate3_pkg::*;
#(
  parameter logic [7:0] EXPECT_TT     = 8'h7F,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         LOOPS         = 1,
  parameter int         ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             drv_a,
  output logic             drv_b,
  output logic             drv_c,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       first_fail_vec
);

  localparam state_e              AFTER_VEC   = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [ERR_W-1:0]    ERR_MAX     = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0]    ERR_ZERO    = {ERR_W{1'b0}};

  state_e              state_r, state_nxt_s;
  logic [SETTLE_W-1:0] settle_cnt_r;
  logic [VEC_W-1:0]    vec_s;
  logic                last_vec_s, clear_s, advance_s, accept_s, compare_s, abort_s, mismatch_s;
  logic [ERR_W-1:0]    err_nxt_s, err_count_r;
  logic [VEC_W-1:0]    ff_nxt_s, first_fail_r;
  logic                busy_r, done_r, pass_r;

  gate3_vec_gen #(.LOOPS(LOOPS)) u_vec_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear_s),
    .advance  (advance_s),
    .vec      (vec_s),
    .last_vec (last_vec_s)
  );

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and sequencing strobes; abort pre-empts the compare of the same cycle
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    compare_s   = 1'b0;
    clear_s     = 1'b0;
    advance_s   = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s    = 1'b1;
          clear_s     = 1'b1;
          state_nxt_s = AFTER_VEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          abort_s     = 1'b1;
          clear_s     = 1'b1;
          state_nxt_s = IDLE;
        end else if (settle_cnt_r == SETTLE_LAST) begin
          state_nxt_s = CHECK;
        end else begin
          state_nxt_s = SETTLE;
        end
      end
      CHECK: begin
        if (abort) begin
          abort_s     = 1'b1;
          clear_s     = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          compare_s = 1'b1;
          if (last_vec_s) begin
            state_nxt_s = DONE;
          end else begin
            advance_s   = 1'b1;
            state_nxt_s = AFTER_VEC;
          end
        end
      end
      DONE: begin
        abort_s     = abort;
        clear_s     = 1'b1;
        state_nxt_s = IDLE;
      end
      default: begin
        clear_s     = 1'b1;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Dwell counter for the settle window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt_r <= 4'd0;
    end else if ((state_r == SETTLE) && (state_nxt_s == SETTLE)) begin
      settle_cnt_r <= settle_cnt_r + 4'd1;
    end else begin
      settle_cnt_r <= 4'd0;
    end
  end

  assign mismatch_s = compare_s && (dut_y != tt_bit(EXPECT_TT, vec_s));

  // Scoreboard update: saturating error count, first failing vector latched while count is zero
  always_comb begin
    err_nxt_s = err_count_r;
    ff_nxt_s  = first_fail_r;
    if (accept_s) begin
      err_nxt_s = ERR_ZERO;
      ff_nxt_s  = 3'd0;
    end else if (mismatch_s) begin
      if (err_count_r == ERR_MAX) begin
        err_nxt_s = err_count_r;
      end else begin
        err_nxt_s = err_count_r + ERR_W'(1);
      end
      if (err_count_r == ERR_ZERO) begin
        ff_nxt_s = vec_s;
      end else begin
        ff_nxt_s = first_fail_r;
      end
    end else begin
      err_nxt_s = err_count_r;
      ff_nxt_s  = first_fail_r;
    end
  end

  // Registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      err_count_r  <= ERR_ZERO;
      first_fail_r <= 3'd0;
    end else begin
      busy_r       <= (state_nxt_s == SETTLE) || (state_nxt_s == CHECK);
      done_r       <= (state_nxt_s == DONE);
      err_count_r  <= err_nxt_s;
      first_fail_r <= ff_nxt_s;
      if (accept_s || abort_s) begin
        pass_r <= 1'b0;
      end else if (state_nxt_s == DONE) begin
        pass_r <= (err_nxt_s == ERR_ZERO);
      end
    end
  end

  assign drv_a          = vec_s[2];
  assign drv_b          = vec_s[1];
  assign drv_c          = vec_s[0];
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign err_count      = err_count_r;
  assign first_fail_vec = first_fail_r;

endmodule

// File: tb/tb_gate3_exerciser.sv
// Randomized scoreboard bench: two exerciser configurations share start/abort and each
// drives its own behavioural gate; a monitor scores every run end against a reference model.
module tb_gate3_exerciser;
  import gate3_pkg::*;

  localparam int S_A = 2, L_A = 1, W_A = 4;
  localparam int S_B = 0, L_B = 2, W_B = 3;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [7:0] gate_tt = 8'h7F;
  logic drv_a_a, drv_b_a, drv_c_a, busy_a, done_a, pass_a, y_a;
  logic drv_a_b, drv_b_b, drv_c_b, busy_b, done_b, pass_b, y_b;
  logic [3:0] err_a;
  logic [2:0] err_b, ff_a, ff_b;

  typedef struct {
    int done; int pass; int err; int ff; int drv; int cycles;
  } exp_t;

  exp_t q_a[$], q_b[$];
  int checks = 0, errors = 0, done_exp = 0;
  int done_seen[2];

  always #5 clk = ~clk;

  assign y_a = gate_tt[{drv_a_a, drv_b_a, drv_c_a}];
  assign y_b = gate_tt[{drv_a_b, drv_b_b, drv_c_b}];

  gate3_exerciser #(.EXPECT_TT(TT_NAND3), .SETTLE_CYCLES(S_A), .LOOPS(L_A), .ERR_W(W_A)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .drv_a(drv_a_a), .drv_b(drv_b_a), .drv_c(drv_c_a), .dut_y(y_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .first_fail_vec(ff_a));

  gate3_exerciser #(.EXPECT_TT(TT_NAND3), .SETTLE_CYCLES(S_B), .LOOPS(L_B), .ERR_W(W_B)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .drv_a(drv_a_b), .drv_b(drv_b_b), .drv_c(drv_c_b), .dut_y(y_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .first_fail_vec(ff_b));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: m=0 is a full run, otherwise abort is sampled m edges after the accept edge
  function automatic exp_t model(input int s, input int l, input int w, input logic [7:0] g, input int m);
    exp_t e;
    int n, cnt, maxv;
    bit seen;
    logic [7:0] tt;
    tt = TT_NAND3;
    n = (m == 0) ? 8 * l : (m - 1) / (s + 1);
    if (n > 8 * l) n = 8 * l;
    cnt = 0; seen = 1'b0; e.ff = 0;
    for (int j = 0; j < n; j++) begin
      if (g[j % 8] != tt[j % 8]) begin
        if (!seen) e.ff = j % 8;
        seen = 1'b1;
        cnt++;
      end
    end
    maxv     = (1 << w) - 1;
    e.err    = (cnt > maxv) ? maxv : cnt;
    e.done   = (m == 0) ? 1 : 0;
    e.pass   = ((m == 0) && (cnt == 0)) ? 1 : 0;
    e.drv    = (m == 0) ? 7 : 0;
    e.cycles = (m == 0) ? 8 * l * (s + 1) : m;
    return e;
  endfunction

  // Monitor: per-cycle drive sequence while busy, full scoring whenever busy falls
  initial begin
    bit   prev[2];
    int   cyc[2];
    logic b_s, d_s;
    int   p_s, e_s, f_s, v_s, s_k;
    string nm;
    exp_t e;
    prev[0] = 1'b0; prev[1] = 1'b0; cyc[0] = 0; cyc[1] = 0;
    done_seen[0] = 0; done_seen[1] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev[0] = 1'b0; prev[1] = 1'b0; cyc[0] = 0; cyc[1] = 0;
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (k == 0) begin
            b_s = busy_a; d_s = done_a; p_s = int'(pass_a); e_s = int'(err_a); f_s = int'(ff_a);
            v_s = int'({drv_a_a, drv_b_a, drv_c_a}); s_k = S_A; nm = "A";
          end else begin
            b_s = busy_b; d_s = done_b; p_s = int'(pass_b); e_s = int'(err_b); f_s = int'(ff_b);
            v_s = int'({drv_a_b, drv_b_b, drv_c_b}); s_k = S_B; nm = "B";
          end
          if (b_s) begin
            check({nm, "_drv_step"}, v_s, (cyc[k] / (s_k + 1)) % 8);
            cyc[k]++;
          end
          if (d_s) done_seen[k]++;
          if (prev[k] && !b_s) begin
            if ((k == 0 && q_a.size() == 0) || (k == 1 && q_b.size() == 0)) begin
              checks++; errors++;
              $display("FAIL %s_unexpected_end: run ended with nothing expected", nm);
            end else begin
              e = (k == 0) ? q_a.pop_front() : q_b.pop_front();
              check({nm, "_done"}, int'(d_s), e.done);
              check({nm, "_pass"}, p_s, e.pass);
              check({nm, "_err_count"}, e_s, e.err);
              check({nm, "_first_fail"}, f_s, e.ff);
              check({nm, "_drv_end"}, v_s, e.drv);
              check({nm, "_busy_cycles"}, cyc[k], e.cycles);
            end
            cyc[k] = 0;
          end
          prev[k] = b_s;
        end
      end
    end
  end

  task automatic run(input logic [7:0] g, input int m, input int xs, input bit with_abort);
    gate_tt = g;
    q_a.push_back(model(S_A, L_A, W_A, g, m));
    q_b.push_back(model(S_B, L_B, W_B, g, m));
    if (m == 0) done_exp++;
    @(posedge clk); #1; start = 1'b1; abort = with_abort;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      start = (c == xs);
      abort = (c == m);
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      if (!busy_a && !busy_b) break;
    end
    checks++;
    if (busy_a || busy_b) begin
      errors++;
      $display("FAIL run_timeout: busy_a=%0b busy_b=%0b required 0", busy_a, busy_b);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_A_outs"}, int'({drv_a_a, drv_b_a, drv_c_a, busy_a, done_a, pass_a, err_a, ff_a}), 0);
    check({tag, "_B_outs"}, int'({drv_a_b, drv_b_b, drv_c_b, busy_b, done_b, pass_b, err_b, ff_b}), 0);
  endtask

  initial begin
    int m, xs;
    logic [7:0] g;
    #12;
    check_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    run(TT_NAND3, 0, 3, 1'b0);   // good gate, stray start while busy
    run(8'hFF, 0, 0, 1'b0);      // stuck-at-1
    run(8'h00, 0, 0, 1'b0);      // stuck-at-0, B saturates
    run(8'h00, 13, 5, 1'b0);     // abort while A holds vector 4 in SETTLE

    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    check("idle_abort_busy_A", int'(busy_a), 0);
    check("idle_abort_busy_B", int'(busy_b), 0);

    run(TT_NAND3, 0, 0, 1'b1);   // start and abort together in IDLE

    for (int i = 0; i < 10; i++) begin
      g  = ($urandom_range(0, 3) == 0) ? TT_NAND3 : 8'($urandom);
      m  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 16)) : 0;
      xs = (m == 0) ? int'($urandom_range(1, 14)) : ((m > 1) ? int'($urandom_range(1, m - 1)) : 0);
      run(g, m, xs, 1'b0);
    end

    gate_tt = 8'h00;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3; rst_n = 1'b0;
    #1; check_all_zero("async_reset");
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    run(TT_NAND3, 0, 0, 1'b0);

    repeat (3) @(posedge clk);
    check("A_done_pulses", done_seen[0], done_exp);
    check("B_done_pulses", done_seen[1], done_exp);
    check("A_queue_left", q_a.size(), 0);
    check("B_queue_left", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate3_exerciser.md
Name: gate3_exerciser

Overview:
Sequential stimulus/response engine that drives the three inputs of a 3-input combinational gate and checks its output. It steps exhaustively through all 8 input vectors and compares the sampled output against a truth-table parameter. It reports pass/fail, a mismatch count and the first failing vector. It sits on the input/output pins of the gate under test, in the same clock domain, and serves as on-chip self-test for the gate library cells.

Parameters:
EXPECT_TT, 8'h7F, expected truth table; bit i = expected y for vector i = {a,b,c} (8'h7F = NAND3)
SETTLE_CYCLES, 2, idle cycles after a vector is applied before sampling; legal 0..15
LOOPS, 1, number of full 8-vector sweeps per run; legal 1..16
ERR_W, 4, err_count width; counter saturates at all-ones

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a run; sampled only in IDLE
abort  input  1  terminate the current run; return to IDLE without asserting done
drv_a  output  1  gate input a (registered)
drv_b  output  1  gate input b (registered)
drv_c  output  1  gate input c (registered)
dut_y  input  1  gate output; combinational from drv_*
busy  output  1  high from the start-accept edge until the DONE state is entered
done  output  1  one-cycle pulse at run completion
pass  output  1  err_count==0 at last completion; held until the next start
err_count  output  ERR_W  mismatches in the last run; saturating
first_fail_vec  output  3  {a,b,c} of the first mismatch; 0 if none

Behaviour:
- Reset (async, rst_n=0): state=IDLE; drv_a/b/c=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, internal vector/loop/settle counters=0.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE: start=1 at an edge causes the following on that edge:
  - vec=0 on drv_*; loop=0; err_count=0; first_fail_vec=0; pass=0; busy=1.
  - Next state is SETTLE if SETTLE_CYCLES>0, else CHECK.
- SETTLE: stays exactly SETTLE_CYCLES cycles (counter), then goes to CHECK. drv_* is held.
- CHECK: exactly one cycle. At its ending edge, dut_y is compared with EXPECT_TT[vec].
  - Mismatch: err_count increments (saturating at 2^ERR_W-1). If this is the first mismatch of the run, first_fail_vec=vec.
  - If vec==7 and loop==LOOPS-1: go to DONE.
  - Otherwise: vec=vec+1 (wraps 7->0, and loop increments on that wrap); drv_* updates on the same edge; go to SETTLE (or CHECK if SETTLE_CYCLES=0).
- Per-vector timing: each vector occupies SETTLE_CYCLES+1 cycles. A run lasts 8*LOOPS*(SETTLE_CYCLES+1) cycles from the start-accept edge to DONE entry.
- DONE: one cycle. done=1, busy=0, pass=(err_count==0 including the final compare). drv_* returns to 0 at the exit edge. Next state is IDLE.
- start while busy or in DONE: ignored. A run is not queued.
- abort (any state except IDLE):
  - Next edge: state=IDLE, busy=0, drv_*=0, done stays 0.
  - err_count and first_fail_vec keep their partial values; pass=0.
  - abort has priority over the CHECK compare in the same cycle; that compare is discarded.
  - abort in IDLE: no effect.
- Simultaneous start and abort in IDLE: start wins; abort is ignored in IDLE.
- Reset mid-run: immediate return to reset values. No done pulse.
- Outputs pass/err_count/first_fail_vec are stable whenever busy=0.

Decomposition:
- Shared package gate3_pkg:
  - state enum (IDLE, SETTLE, CHECK, DONE)
  - constants TT_NAND3=8'h7F, TT_AND3=8'h80, TT_NOR3=8'h01, VEC_W=3
- One natural sub-module, gate3_vec_gen:
  - vector counter plus loop counter with clear/advance inputs and a last_vec output
  - FSM, settle timer and scoreboard stay in the top module.

Test Plan:
- Good NAND3 behind the exerciser, defaults; pulse start -> busy for 24 cycles, drv_* steps 0..7, done pulses once at cycle 24, pass=1, err_count=0, first_fail_vec=0.
- Gate output stuck-at-1 (dut_y=1), defaults -> one mismatch at vec 7; done with pass=0, err_count=1, first_fail_vec=3'b111.
- Gate stuck-at-0, LOOPS=2, ERR_W=4 -> 14 mismatches; err_count=14, first_fail_vec=0. Same bench with ERR_W=3 -> err_count saturates at 7.
- SETTLE_CYCLES=0, good NAND3 -> each vector lasts 1 cycle, done at cycle 8, pass=1. A start pulsed at cycle 3 is ignored (only one done seen).
- Abort asserted while vec=4 in SETTLE with a stuck-at-0 gate -> next edge IDLE, busy=0, no done, drv_*=0, err_count=4, first_fail_vec=0, pass=0.
- rst_n dropped asynchronously mid-CHECK -> all outputs 0 immediately. After release, start runs a clean full sweep to pass=1.
